// File: rtl/e203_exu_oitf_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : e203_exu_oitf_ctrl_pkg
// Brief    : Shared e203 OITF sizing constants, entry payload type, match helper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package e203_exu_oitf_ctrl_pkg;

  localparam int E203_OITF_DEPTH = 2;
  localparam int E203_ITAG_W     = $clog2(E203_OITF_DEPTH);
  localparam int E203_RFIDX_W    = 5;
  localparam int E203_PC_SIZE    = 32;

  typedef struct packed {
    logic                    rdwen;
    logic                    rdfpu;
    logic [E203_RFIDX_W-1:0] rdidx;
    logic [E203_PC_SIZE-1:0] pc;
  } oitf_entry_t;

  // One entry's contribution to a dispatch-side dependency check.
  function automatic logic oitf_rd_hit(
    input logic                    valid,
    input oitf_entry_t             ent,
    input logic                    en,
    input logic [E203_RFIDX_W-1:0] idx,
    input logic                    fpu
  );
    return valid & ent.rdwen & en & (ent.rdidx == idx) & (ent.rdfpu == fpu);
  endfunction

endpackage

`default_nettype wire

// File: rtl/e203_exu_oitf_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : e203_exu_oitf_ctrl_if
// Brief    : Dispatch, retire and dependency-match signals of the OITF.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface e203_exu_oitf_ctrl_if
  import e203_exu_oitf_ctrl_pkg::*;
#(
  parameter int ITAG_W  = E203_ITAG_W,
  parameter int PC_SIZE = E203_PC_SIZE
) ();

  logic                    dis_ena;
  logic                    dis_ready;
  logic [ITAG_W-1:0]       dis_ptr;

  logic                    disp_rs1en;
  logic                    disp_rs2en;
  logic                    disp_rs3en;
  logic                    disp_rdwen;
  logic [E203_RFIDX_W-1:0] disp_rs1idx;
  logic [E203_RFIDX_W-1:0] disp_rs2idx;
  logic [E203_RFIDX_W-1:0] disp_rs3idx;
  logic [E203_RFIDX_W-1:0] disp_rdidx;
  logic                    disp_rs1fpu;
  logic                    disp_rs2fpu;
  logic                    disp_rs3fpu;
  logic                    disp_rdfpu;
  logic [PC_SIZE-1:0]      disp_pc;

  logic                    ret_ena;
  logic [ITAG_W-1:0]       ret_ptr;
  logic                    ret_rdwen;
  logic                    ret_rdfpu;
  logic [E203_RFIDX_W-1:0] ret_rdidx;
  logic [PC_SIZE-1:0]      ret_pc;

  logic                    oitfrd_match_disprs1;
  logic                    oitfrd_match_disprs2;
  logic                    oitfrd_match_disprs3;
  logic                    oitfrd_match_disprd;
  logic                    oitf_empty;

  modport master (
    output dis_ena, disp_rs1en, disp_rs2en, disp_rs3en, disp_rdwen,
           disp_rs1idx, disp_rs2idx, disp_rs3idx, disp_rdidx,
           disp_rs1fpu, disp_rs2fpu, disp_rs3fpu, disp_rdfpu, disp_pc, ret_ena,
    input  dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdfpu, ret_rdidx, ret_pc,
           oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3,
           oitfrd_match_disprd, oitf_empty
  );

  modport slave (
    input  dis_ena, disp_rs1en, disp_rs2en, disp_rs3en, disp_rdwen,
           disp_rs1idx, disp_rs2idx, disp_rs3idx, disp_rdidx,
           disp_rs1fpu, disp_rs2fpu, disp_rs3fpu, disp_rdfpu, disp_pc, ret_ena,
    output dis_ready, dis_ptr, ret_ptr, ret_rdwen, ret_rdfpu, ret_rdidx, ret_pc,
           oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3,
           oitfrd_match_disprd, oitf_empty
  );

endinterface

`default_nettype wire

// File: rtl/e203_exu_oitf_ptr.sv
//------------------------------------------------------------------------------
// Module   : e203_exu_oitf_ptr
// Brief    : Circular-buffer pointer with wrap flag, increment enable, sync reset.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module e203_exu_oitf_ptr #(
  parameter int DEPTH = 2,
  parameter int PTR_W = 1
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             inc_i,
  output logic      [PTR_W-1:0] ptr_o,
  output logic                  flag_o
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ONE  = PTR_W'(1);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             flag_q, flag_d;

  always_comb begin
    ptr_d  = ptr_q;
    flag_d = flag_q;
    if (inc_i) begin
      if (ptr_q == LAST) begin
        ptr_d  = '0;
        flag_d = ~flag_q;
      end else begin
        ptr_d  = ptr_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      flag_q <= flag_d;
    end
  end

  assign ptr_o  = ptr_q;
  assign flag_o = flag_q;

endmodule

`default_nettype wire

// File: rtl/e203_exu_oitf_ctrl.sv
//------------------------------------------------------------------------------
// Module   : e203_exu_oitf_ctrl
// Brief    : Outstanding-instruction track FIFO with rd-dependency matching.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module e203_exu_oitf_ctrl
  import e203_exu_oitf_ctrl_pkg::*;
#(
  parameter int OITF_DEPTH = E203_OITF_DEPTH,
  parameter int ITAG_W     = $clog2(OITF_DEPTH)
) (
  input  wire logic           clk,
  input  wire logic           rst,
  e203_exu_oitf_ctrl_if.slave oitf
);

  logic [ITAG_W-1:0] alloc_ptr;
  logic [ITAG_W-1:0] ret_ptr;
  logic              alloc_flag;
  logic              ret_flag;
  logic              ptr_eq;
  logic              empty;
  logic              full;
  logic              alloc_fire;
  logic              ret_fire;

  assign ptr_eq     = (alloc_ptr == ret_ptr);
  assign empty      = ptr_eq & (alloc_flag == ret_flag);
  assign full       = ptr_eq & (alloc_flag != ret_flag);
  assign alloc_fire = oitf.dis_ena & ~full;
  assign ret_fire   = oitf.ret_ena & ~empty;

  e203_exu_oitf_ptr #(
    .DEPTH (OITF_DEPTH),
    .PTR_W (ITAG_W)
  ) u_alloc_ptr (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (alloc_fire),
    .ptr_o  (alloc_ptr),
    .flag_o (alloc_flag)
  );

  e203_exu_oitf_ptr #(
    .DEPTH (OITF_DEPTH),
    .PTR_W (ITAG_W)
  ) u_ret_ptr (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (ret_fire),
    .ptr_o  (ret_ptr),
    .flag_o (ret_flag)
  );

  oitf_entry_t           disp_ent;
  oitf_entry_t           ent_pl [OITF_DEPTH];
  logic [OITF_DEPTH-1:0] ent_vld;
  logic [OITF_DEPTH-1:0] hit_rs1;
  logic [OITF_DEPTH-1:0] hit_rs2;
  logic [OITF_DEPTH-1:0] hit_rs3;
  logic [OITF_DEPTH-1:0] hit_rd;

  assign disp_ent.rdwen = oitf.disp_rdwen;
  assign disp_ent.rdfpu = oitf.disp_rdfpu;
  assign disp_ent.rdidx = oitf.disp_rdidx;
  assign disp_ent.pc    = oitf.disp_pc;

  for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_entry
    logic        valid_q;
    oitf_entry_t pl_q;
    logic        set;
    logic        clr;

    assign set = alloc_fire & (alloc_ptr == ITAG_W'(i));
    assign clr = ret_fire & (ret_ptr == ITAG_W'(i));

    // Set and clear of one index never coincide: that needs a full or empty buffer.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else if (set) begin
        valid_q <= 1'b1;
      end else if (clr) begin
        valid_q <= 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (set) begin
        pl_q <= disp_ent;
      end
    end

    assign ent_vld[i] = valid_q;
    assign ent_pl[i]  = pl_q;
    assign hit_rs1[i] = oitf_rd_hit(valid_q, pl_q, oitf.disp_rs1en, oitf.disp_rs1idx, oitf.disp_rs1fpu);
    assign hit_rs2[i] = oitf_rd_hit(valid_q, pl_q, oitf.disp_rs2en, oitf.disp_rs2idx, oitf.disp_rs2fpu);
    assign hit_rs3[i] = oitf_rd_hit(valid_q, pl_q, oitf.disp_rs3en, oitf.disp_rs3idx, oitf.disp_rs3fpu);
    assign hit_rd[i]  = oitf_rd_hit(valid_q, pl_q, oitf.disp_rdwen, oitf.disp_rdidx, oitf.disp_rdfpu);
  end

  oitf_entry_t ret_ent;
  logic        unused_vld;

  assign ret_ent    = ent_pl[ret_ptr];
  assign unused_vld = ^ent_vld;

  assign oitf.dis_ready            = ~full;
  assign oitf.dis_ptr              = alloc_ptr;
  assign oitf.ret_ptr              = ret_ptr;
  assign oitf.ret_rdwen            = ret_ent.rdwen;
  assign oitf.ret_rdfpu            = ret_ent.rdfpu;
  assign oitf.ret_rdidx            = ret_ent.rdidx;
  assign oitf.ret_pc               = ret_ent.pc;
  assign oitf.oitfrd_match_disprs1 = |hit_rs1;
  assign oitf.oitfrd_match_disprs2 = |hit_rs2;
  assign oitf.oitfrd_match_disprs3 = |hit_rs3;
  assign oitf.oitfrd_match_disprd  = |hit_rd;
  assign oitf.oitf_empty           = empty;

endmodule

`default_nettype wire

// File: tb/tb_e203_exu_oitf_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_e203_exu_oitf_ctrl
// Brief    : Directed self-checking bench for the depth-2 OITF controller.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_e203_exu_oitf_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  e203_exu_oitf_ctrl_if #(.ITAG_W(1), .PC_SIZE(32)) oif ();

  e203_exu_oitf_ctrl #(
    .OITF_DEPTH (2),
    .ITAG_W     (1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .oitf (oif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    oif.dis_ena     = 1'b0;
    oif.ret_ena     = 1'b0;
    oif.disp_rs1en  = 1'b0;
    oif.disp_rs2en  = 1'b0;
    oif.disp_rs3en  = 1'b0;
    oif.disp_rdwen  = 1'b0;
    oif.disp_rs1idx = '0;
    oif.disp_rs2idx = '0;
    oif.disp_rs3idx = '0;
    oif.disp_rdidx  = '0;
    oif.disp_rs1fpu = 1'b0;
    oif.disp_rs2fpu = 1'b0;
    oif.disp_rs3fpu = 1'b0;
    oif.disp_rdfpu  = 1'b0;
    oif.disp_pc     = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic alloc(input logic [4:0] idx, input logic fpu, input logic [31:0] pc);
    oif.dis_ena    = 1'b1;
    oif.disp_rdwen = 1'b1;
    oif.disp_rdidx = idx;
    oif.disp_rdfpu = fpu;
    oif.disp_pc    = pc;
    step();
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Post-reset state, with live dispatch operands that must not hit.
    oif.disp_rs1en = 1'b1;
    oif.disp_rdwen = 1'b1;
    #1;
    chk("rst_empty", 32'(oif.oitf_empty), 32'd1);
    chk("rst_ready", 32'(oif.dis_ready), 32'd1);
    chk("rst_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("rst_ret_ptr", 32'(oif.ret_ptr), 32'd0);
    chk("rst_m_rs1", 32'(oif.oitfrd_match_disprs1), 32'd0);
    chk("rst_m_rd", 32'(oif.oitfrd_match_disprd), 32'd0);
    idle();

    // Retire while empty is ignored.
    oif.ret_ena = 1'b1;
    step();
    idle();
    #1;
    chk("ret_empty_ret_ptr", 32'(oif.ret_ptr), 32'd0);
    chk("ret_empty_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("ret_empty_empty", 32'(oif.oitf_empty), 32'd1);

    // Single allocation of x5.
    alloc(5'd5, 1'b0, 32'h100);
    #1;
    chk("a1_empty", 32'(oif.oitf_empty), 32'd0);
    chk("a1_dis_ptr", 32'(oif.dis_ptr), 32'd1);
    chk("a1_ret_ptr", 32'(oif.ret_ptr), 32'd0);
    chk("a1_ready", 32'(oif.dis_ready), 32'd1);
    chk("a1_ret_rdwen", 32'(oif.ret_rdwen), 32'd1);
    chk("a1_ret_rdidx", 32'(oif.ret_rdidx), 32'd5);
    chk("a1_ret_pc", oif.ret_pc, 32'h100);
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1idx = 5'd5;
    #1;
    chk("m_rs1_hit", 32'(oif.oitfrd_match_disprs1), 32'd1);
    oif.disp_rs1en = 1'b0;
    #1;
    chk("m_rs1_en0", 32'(oif.oitfrd_match_disprs1), 32'd0);
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1fpu = 1'b1;
    #1;
    chk("m_rs1_fpu", 32'(oif.oitfrd_match_disprs1), 32'd0);
    oif.disp_rs1fpu = 1'b0;
    oif.disp_rs2en = 1'b1;
    oif.disp_rs2idx = 5'd5;
    oif.disp_rs3en = 1'b1;
    oif.disp_rs3idx = 5'd6;
    oif.disp_rdwen = 1'b1;
    oif.disp_rdidx = 5'd5;
    #1;
    chk("m_all_rs1", 32'(oif.oitfrd_match_disprs1), 32'd1);
    chk("m_all_rs2", 32'(oif.oitfrd_match_disprs2), 32'd1);
    chk("m_all_rs3", 32'(oif.oitfrd_match_disprs3), 32'd0);
    chk("m_all_rd", 32'(oif.oitfrd_match_disprd), 32'd1);
    idle();

    // Simultaneous alloc (x9) and retire at occupancy 1.
    oif.ret_ena = 1'b1;
    alloc(5'd9, 1'b0, 32'h200);
    #1;
    chk("ar_empty", 32'(oif.oitf_empty), 32'd0);
    chk("ar_ready", 32'(oif.dis_ready), 32'd1);
    chk("ar_ret_ptr", 32'(oif.ret_ptr), 32'd1);
    chk("ar_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("ar_ret_rdidx", 32'(oif.ret_rdidx), 32'd9);
    chk("ar_ret_pc", oif.ret_pc, 32'h200);
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1idx = 5'd5;
    oif.disp_rs2en = 1'b1;
    oif.disp_rs2idx = 5'd9;
    #1;
    chk("ar_m_old", 32'(oif.oitfrd_match_disprs1), 32'd0);
    chk("ar_m_new", 32'(oif.oitfrd_match_disprs2), 32'd1);
    idle();

    // Drain, then fill to full.
    oif.ret_ena = 1'b1;
    step();
    idle();
    #1;
    chk("drain_empty", 32'(oif.oitf_empty), 32'd1);
    chk("drain_ret_ptr", 32'(oif.ret_ptr), 32'd0);
    alloc(5'd3, 1'b0, 32'h300);
    alloc(5'd4, 1'b0, 32'h400);
    #1;
    chk("full_ready", 32'(oif.dis_ready), 32'd0);
    chk("full_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("full_empty", 32'(oif.oitf_empty), 32'd0);
    chk("full_ret_rdidx", 32'(oif.ret_rdidx), 32'd3);

    // Allocation while full is ignored.
    alloc(5'd7, 1'b0, 32'h700);
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1idx = 5'd7;
    oif.disp_rs2en = 1'b1;
    oif.disp_rs2idx = 5'd4;
    oif.disp_rs3en = 1'b1;
    oif.disp_rs3idx = 5'd3;
    #1;
    chk("ovf_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("ovf_ready", 32'(oif.dis_ready), 32'd0);
    chk("ovf_m_x7", 32'(oif.oitfrd_match_disprs1), 32'd0);
    chk("ovf_m_x4", 32'(oif.oitfrd_match_disprs2), 32'd1);
    chk("ovf_m_x3", 32'(oif.oitfrd_match_disprs3), 32'd1);
    chk("ovf_ret_rdidx", 32'(oif.ret_rdidx), 32'd3);
    idle();

    // Retire from full.
    oif.ret_ena = 1'b1;
    step();
    idle();
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1idx = 5'd3;
    #1;
    chk("rf_ret_ptr", 32'(oif.ret_ptr), 32'd1);
    chk("rf_ready", 32'(oif.dis_ready), 32'd1);
    chk("rf_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("rf_m_x3", 32'(oif.oitfrd_match_disprs1), 32'd0);
    chk("rf_ret_rdidx", 32'(oif.ret_rdidx), 32'd4);
    chk("rf_ret_pc", oif.ret_pc, 32'h400);
    idle();

    // Refill to full, then reset.
    alloc(5'd8, 1'b0, 32'h800);
    #1;
    chk("refull_ready", 32'(oif.dis_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1idx = 5'd4;
    oif.disp_rs2en = 1'b1;
    oif.disp_rs2idx = 5'd8;
    oif.disp_rdwen = 1'b1;
    oif.disp_rdidx = 5'd4;
    #1;
    chk("frst_empty", 32'(oif.oitf_empty), 32'd1);
    chk("frst_ready", 32'(oif.dis_ready), 32'd1);
    chk("frst_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("frst_ret_ptr", 32'(oif.ret_ptr), 32'd0);
    chk("frst_m_rs1", 32'(oif.oitfrd_match_disprs1), 32'd0);
    chk("frst_m_rs2", 32'(oif.oitfrd_match_disprs2), 32'd0);
    chk("frst_m_rd", 32'(oif.oitfrd_match_disprd), 32'd0);
    idle();

    // Reset wins over a simultaneous alloc and retire.
    alloc(5'd10, 1'b0, 32'hA00);
    rst = 1'b1;
    oif.ret_ena = 1'b1;
    alloc(5'd11, 1'b0, 32'hB00);
    rst = 1'b0;
    oif.disp_rs1en = 1'b1;
    oif.disp_rs1idx = 5'd11;
    oif.disp_rs2en = 1'b1;
    oif.disp_rs2idx = 5'd10;
    #1;
    chk("rpri_empty", 32'(oif.oitf_empty), 32'd1);
    chk("rpri_dis_ptr", 32'(oif.dis_ptr), 32'd0);
    chk("rpri_m_new", 32'(oif.oitfrd_match_disprs1), 32'd0);
    chk("rpri_m_old", 32'(oif.oitfrd_match_disprs2), 32'd0);
    idle();

    // Five alloc/retire pairs: pointers run 0,1,0,1,0.
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("wrap%0d_dis_ptr", i), 32'(oif.dis_ptr), 32'(i % 2));
      chk($sformatf("wrap%0d_ret_ptr", i), 32'(oif.ret_ptr), 32'(i % 2));
      chk($sformatf("wrap%0d_empty0", i), 32'(oif.oitf_empty), 32'd1);
      alloc(5'(16 + i), 1'b1, 32'(i));
      oif.disp_rs3en = 1'b1;
      oif.disp_rs3idx = 5'(16 + i);
      oif.disp_rs3fpu = 1'b1;
      #1;
      chk($sformatf("wrap%0d_empty1", i), 32'(oif.oitf_empty), 32'd0);
      chk($sformatf("wrap%0d_m_rs3", i), 32'(oif.oitfrd_match_disprs3), 32'd1);
      chk($sformatf("wrap%0d_ret_rdfpu", i), 32'(oif.ret_rdfpu), 32'd1);
      idle();
      oif.ret_ena = 1'b1;
      step();
      idle();
    end
    #1;
    chk("wrap_end_dis_ptr", 32'(oif.dis_ptr), 32'd1);
    chk("wrap_end_ret_ptr", 32'(oif.ret_ptr), 32'd1);
    chk("wrap_end_empty", 32'(oif.oitf_empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/e203_exu_oitf_ctrl.md
E203_EXU_OITF_CTRL -- requirements
Module: e203_exu_oitf_ctrl

Interface
REQ-001 SHALL have parameter OITF_DEPTH, default 2, number of outstanding long-pipe entries; power of two, >=2.
REQ-002 SHALL have parameter ITAG_W, default log2(OITF_DEPTH), width of entry tag.
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port dis_ena, input, 1, allocate one entry this cycle.
REQ-006 SHALL have port dis_ready, output, 1, entry available.
REQ-007 SHALL have port dis_ptr, output, ITAG_W, tag the next allocation receives.
REQ-008 SHALL have ports disp_rs1en/rs2en/rs3en/rdwen, input, 1 each, operand enables of the instruction being dispatched.
REQ-009 SHALL have ports disp_rs1idx/rs2idx/rs3idx/rdidx, input, 5 each, register indexes.
REQ-010 SHALL have ports disp_rs1fpu/rs2fpu/rs3fpu/rdfpu, input, 1 each, FPU register-file selects.
REQ-011 SHALL have port disp_pc, input, PC_SIZE, PC stored with the entry.
REQ-012 SHALL have port ret_ena, input, 1, retire oldest entry this cycle.
REQ-013 SHALL have port ret_ptr, output, ITAG_W, tag of oldest entry.
REQ-014 SHALL have ports ret_rdwen/ret_rdfpu (1), ret_rdidx (5), ret_pc (PC_SIZE), outputs, oldest entry payload.
REQ-015 SHALL have ports oitfrd_match_disprs1/rs2/rs3/rd, output, 1 each, dependency hits.
REQ-016 SHALL have port oitf_empty, output, 1, no valid entry.

Function
REQ-017 Storage SHALL be a circular buffer of OITF_DEPTH entries (valid, rdwen, rdfpu, rdidx, pc).
REQ-018 Alloc pointer SHALL advance by 1 on dis_ena & dis_ready and wrap to 0 after OITF_DEPTH-1, toggling an alloc wrap flag.
REQ-019 Retire pointer SHALL advance by 1 on ret_ena & ~oitf_empty and wrap identically, toggling a retire wrap flag.
REQ-020 oitf_empty SHALL be 1 when the pointers are equal and the flags are equal; full when the pointers are equal and the flags differ.
REQ-021 dis_ready SHALL be ~full, with no combinational dependence on ret_ena (no same-cycle pass-through).
REQ-022 On allocation, entry[alloc_ptr] SHALL capture valid=1 and the payload on the same edge; the entry is visible to the match logic the next cycle.
REQ-023 On retire, entry[ret_ptr].valid SHALL clear on the same edge.
REQ-024 Simultaneous alloc and retire SHALL both take effect; occupancy is unchanged; this is legal at any non-empty, non-full level.
REQ-025 ret_ena while empty SHALL be ignored, leaving state unchanged; dis_ena while full SHALL be ignored.
REQ-026 oitfrd_match_disprsN SHALL be the OR over entries of: valid & rdwen & disp_rsNen & (rdidx==disp_rsNidx) & (rdfpu==disp_rsNfpu).
REQ-027 oitfrd_match_disprd SHALL use the same rule with disp_rdwen/rdidx/rdfpu.
REQ-028 All match outputs SHALL be purely combinational from registered state plus current disp_* inputs, with zero-cycle latency.
REQ-029 ret_* payload outputs SHALL reflect entry[ret_ptr] combinationally; they are don't-care when oitf_empty=1.
REQ-030 dis_ptr SHALL equal the alloc pointer value; ret_ptr SHALL equal the retire pointer value.

Reset
REQ-031 On rst=1 at a clock edge, both pointers, both wrap flags and all valid bits SHALL clear to 0; payload fields are not reset.
REQ-032 After reset: oitf_empty=1, dis_ready=1, dis_ptr=0, ret_ptr=0, all match outputs=0.
REQ-033 Reset asserted during simultaneous alloc/retire SHALL take priority; no entry is written valid.

Structure
REQ-034 OITF_DEPTH, ITAG width, RFIDX width (5) and PC_SIZE SHALL come from the shared e203 defines package.
REQ-035 One sub-module SHALL implement the wrap-aware pointer (value + flag, inc enable, sync reset): e203_exu_oitf_ptr, instantiated twice.
REQ-036 Entries SHALL be generated per index, with no per-entry module.

Verification
REQ-037 Reset then idle -> oitf_empty=1, dis_ready=1, dis_ptr=0, all matches 0.
REQ-038 Alloc rdidx=5, rdwen=1; next cycle disp_rs1idx=5, rs1en=1 -> match_disprs1=1; rs1en=0 -> 0; rs1fpu=1 -> 0.
REQ-039 Depth 2, alloc twice -> dis_ready=0, dis_ptr=0; third dis_ena is ignored; retire -> ret_ptr 0->1, dis_ready=1.
REQ-040 Occupancy 1, same-cycle alloc+retire -> occupancy stays 1, ret_ptr and dis_ptr both advance, and match follows the new entry only.
REQ-041 ret_ena while empty -> no pointer change; pointer wrap over 5 alloc/retire pairs -> ptr sequence 0,1,0,1,0, and empty is correct throughout.
REQ-042 Full buffer, assert rst -> next cycle empty=1, matches=0.
